// File: rtl/iir_accumulator.sv
// Back-end accumulator of the time-multiplexed IIR filter: sums the b and a tap products,
// normalises (b_sum - a_sum) by 2^SHIFT with round-half-up, saturates and strobes the result.
module iir_accumulator #(
    parameter int NUM_TAPS = 11,
    parameter int PROD_W   = 32,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 24,
    parameter int SHIFT    = 8
) (
    input  logic              mult_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prod_valid,
    input  logic [3:0]        prod_tap,
    input  logic [PROD_W-1:0] prod_b,
    input  logic [PROD_W-1:0] prod_a,
    input  logic              clr_flags,
    output logic [OUT_W-1:0]  y_data,
    output logic              y_valid,
    output logic              busy,
    output logic              sat,
    output logic              tap_err
);

    localparam int DIFF_W = ACC_W + 2;
    localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);
    localparam logic [DIFF_W-1:0] ROUND_K = {{(DIFF_W-1){1'b0}}, 1'b1} << (SHIFT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc_b;
    logic [ACC_W-1:0]   r_acc_a;
    logic [3:0]         r_expected;
    logic               r_pending;
    logic [OUT_W-1:0]   r_y_data;
    logic               r_y_valid;
    logic               r_sat;
    logic               r_tap_err;

    state_t             w_state_nxt;
    logic [ACC_W-1:0]   w_acc_b_nxt;
    logic [ACC_W-1:0]   w_acc_a_nxt;
    logic [3:0]         w_expected_nxt;
    logic               w_pending_nxt;
    logic [OUT_W-1:0]   w_y_data_nxt;
    logic               w_y_valid_nxt;
    logic               w_sat_set;
    logic               w_err_set;

    logic [ACC_W-1:0]        w_ext_b;
    logic [ACC_W-1:0]        w_ext_a;
    logic signed [DIFF_W-1:0] w_diff;
    logic signed [DIFF_W-1:0] w_shifted;
    logic [DIFF_W-OUT_W:0]   w_hi;
    logic                    w_fits;
    logic [OUT_W-1:0]        w_clipped;

    // Datapath: sign extension, difference, rounding shift and saturation.
    always_comb begin
        w_ext_b   = {{(ACC_W-PROD_W){prod_b[PROD_W-1]}}, prod_b};
        w_ext_a   = {{(ACC_W-PROD_W){prod_a[PROD_W-1]}}, prod_a};
        w_diff    = $signed({{2{r_acc_b[ACC_W-1]}}, r_acc_b}) - $signed({{2{r_acc_a[ACC_W-1]}}, r_acc_a});
        w_shifted = (w_diff + $signed(ROUND_K)) >>> SHIFT;
        w_hi      = w_shifted[DIFF_W-1:OUT_W-1];
        w_fits    = (&w_hi) | ~(|w_hi);
        if (w_fits) begin
            w_clipped = w_shifted[OUT_W-1:0];
        end else if (w_shifted[DIFF_W-1]) begin
            w_clipped = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            w_clipped = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Next-state and next-value logic for the sample-period FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_b_nxt    = r_acc_b;
        w_acc_a_nxt    = r_acc_a;
        w_expected_nxt = r_expected;
        w_pending_nxt  = r_pending;
        w_y_data_nxt   = r_y_data;
        w_y_valid_nxt  = 1'b0;
        w_sat_set      = 1'b0;
        w_err_set      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start || r_pending) begin
                    w_acc_b_nxt    = {ACC_W{1'b0}};
                    w_acc_a_nxt    = {ACC_W{1'b0}};
                    w_expected_nxt = 4'd0;
                    w_pending_nxt  = 1'b0;
                    w_state_nxt    = S_ACCUM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (start) begin
                    w_err_set      = 1'b1;
                    w_acc_b_nxt    = {ACC_W{1'b0}};
                    w_acc_a_nxt    = {ACC_W{1'b0}};
                    w_expected_nxt = 4'd0;
                end else if (prod_valid) begin
                    if (prod_tap == r_expected) begin
                        w_acc_b_nxt    = r_acc_b + w_ext_b;
                        w_acc_a_nxt    = r_acc_a + w_ext_a;
                        w_expected_nxt = r_expected + 4'd1;
                        if (prod_tap == LAST_TAP) begin
                            w_state_nxt = S_FINISH;
                        end else begin
                            w_state_nxt = S_ACCUM;
                        end
                    end else begin
                        w_err_set = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_FINISH: begin
                w_y_data_nxt  = w_clipped;
                w_y_valid_nxt = 1'b1;
                w_sat_set     = ~w_fits;
                w_state_nxt   = S_IDLE;
                if (start) begin
                    w_pending_nxt = 1'b1;
                end else begin
                    w_pending_nxt = r_pending;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, accumulator and output registers; a flag set wins over clr_flags.
    always_ff @(posedge mult_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_acc_b    <= {ACC_W{1'b0}};
            r_acc_a    <= {ACC_W{1'b0}};
            r_expected <= 4'd0;
            r_pending  <= 1'b0;
            r_y_data   <= {OUT_W{1'b0}};
            r_y_valid  <= 1'b0;
            r_sat      <= 1'b0;
            r_tap_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc_b    <= w_acc_b_nxt;
            r_acc_a    <= w_acc_a_nxt;
            r_expected <= w_expected_nxt;
            r_pending  <= w_pending_nxt;
            r_y_data   <= w_y_data_nxt;
            r_y_valid  <= w_y_valid_nxt;
            r_sat      <= w_sat_set | (r_sat & ~clr_flags);
            r_tap_err  <= w_err_set | (r_tap_err & ~clr_flags);
        end
    end

    assign y_data  = r_y_data;
    assign y_valid = r_y_valid;
    assign busy    = (r_state != S_IDLE);
    assign sat     = r_sat;
    assign tap_err = r_tap_err;

endmodule
